// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring sequence checker.
// Decoding helpers work on a word zero-extended to RING_MAX_W bits.
package ring_pkg;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    // The ring advances by rotating right: 1000 -> 0100 -> 0010 -> 0001.
    localparam bit ROT_RIGHT = 1'b1;

    localparam int RING_MAX_W = 32;

    function automatic logic is_onehot(input logic [RING_MAX_W-1:0] w);
        int n;
        n = 0;
        for (int i = 0; i < RING_MAX_W; i++) begin
            if (w[i]) n++;
        end
        return (n == 1);
    endfunction

    function automatic int onehot_to_index(input logic [RING_MAX_W-1:0] w);
        int idx;
        idx = 0;
        for (int i = 0; i < RING_MAX_W; i++) begin
            if (w[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_sequence_checker_onehot_decoder.sv
// Combinational one-hot legality check and hot-bit position decode.
// The index output is only meaningful when o_legal is high.
module onehot_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] i_word,
    output logic             o_legal,
    output logic [IDX_W-1:0] o_index
);

    logic [RING_MAX_W-1:0] w_ext;

    assign w_ext   = RING_MAX_W'(i_word);
    assign o_legal = is_onehot(w_ext);
    assign o_index = IDX_W'(onehot_to_index(w_ext));

endmodule

// File: rtl/ring_sequence_checker.sv
// Ring word decoder plus sequence integrity monitor.
// Locks after LOCK_CNT correct transitions, counts rotations and errors.
module ring_sequence_checker
    import ring_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int IDX_W    = 2,
    parameter int LOCK_CNT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             ring_valid,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             locked,
    output logic             seq_err,
    output logic [CNT_W-1:0] rot_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] START = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [MW-1:0]    r_match;

    logic             w_legal;
    logic [IDX_W-1:0] w_index;
    logic [WIDTH-1:0] w_expected;
    logic             w_correct;

    onehot_decoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_dec (
        .i_word  (ring_in),
        .o_legal (w_legal),
        .o_index (w_index)
    );

    assign w_expected = ROT_RIGHT ? {r_prev[0], r_prev[WIDTH-1:1]}
                                  : {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
    assign w_correct  = (ring_in == w_expected);

    // Lock FSM with registered decode, status and counter outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= HUNT;
            r_prev      <= '0;
            r_match     <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            locked      <= 1'b0;
            seq_err     <= 1'b0;
            rot_count   <= '0;
            err_count   <= '0;
        end else begin
            seq_err <= 1'b0;
            if (ring_valid) begin
                index_valid <= w_legal;
                if (w_legal) begin
                    index  <= w_index;
                    r_prev <= ring_in;
                end
                unique case (r_state)
                    HUNT: begin
                        if (w_legal) begin
                            r_state <= VERIFY;
                            r_match <= '0;
                        end
                    end
                    VERIFY: begin
                        if (w_correct) begin
                            if (r_match == MW'(LOCK_CNT - 1)) begin
                                r_state <= LOCKED;
                                r_match <= '0;
                                locked  <= 1'b1;
                            end else begin
                                r_match <= r_match + 1'b1;
                            end
                        end else if (w_legal) begin
                            r_match <= '0;
                        end else begin
                            r_state <= HUNT;
                            r_match <= '0;
                        end
                    end
                    LOCKED: begin
                        if (w_correct) begin
                            if (ring_in == START) begin
                                rot_count <= rot_count + 1'b1;
                            end
                        end else begin
                            seq_err <= 1'b1;
                            locked  <= 1'b0;
                            r_match <= '0;
                            r_state <= w_legal ? VERIFY : HUNT;
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ring_sequence_checker.md
Name: ring_sequence_checker

Overview:
- Receive-side companion to the team's 4-bit ring counter. It samples a one-hot ring word, decodes the hot-bit position to binary, and checks that each valid sample is the correct successor of the previous one.
- It locks after a run of correct transitions, counts completed rotations and flags sequence errors.
- It sits on the consuming end of any ring-counter-driven sequencing path, as a decoder plus integrity monitor.

Parameters:
- WIDTH, 4: ring word width; must be at least 2.
- IDX_W, 2: index width; equals clog2(WIDTH).
- LOCK_CNT, 2: number of consecutive correct transitions required to enter LOCKED; must be at least 1.
- CNT_W, 8: width of rot_count and err_count.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- ring_in, input, WIDTH: ring word under test.
- ring_valid, input, 1: ring_in is sampled only when this is 1.
- index, output, IDX_W: bit position of the hot bit in the last legal sample.
- index_valid, output, 1: last valid sample was exactly one-hot.
- locked, output, 1: FSM is in LOCKED.
- seq_err, output, 1: one-cycle pulse on a sequence error while LOCKED.
- rot_count, output, CNT_W: completed rotations while locked; wraps modulo 2^CNT_W.
- err_count, output, CNT_W: sequence errors; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = HUNT, prev = 0, match = 0.
  - index = 0, index_valid = 0, locked = 0, seq_err = 0, rot_count = 0, err_count = 0.
- Timing and sampling:
  - All outputs are registered, with one cycle of latency from a sampled ring_valid to the output update.
  - ring_valid = 0: all state and outputs hold, except seq_err, which is driven 0.
- Legal sample: exactly one bit of ring_in is set. All-zero and multi-hot words are illegal.
- Expected successor: expected = {prev[0], prev[WIDTH-1:1]}, i.e. a right-rotate: 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- A correct sample equals expected. A repeated value counts as wrong.
- Every valid sample:
  - index_valid <= legal.
  - If legal, index <= hot-bit position and prev <= ring_in.
  - If illegal, index and prev hold.
- HUNT state:
  - Legal sample: go to VERIFY, match = 0.
  - Illegal sample: stay in HUNT.
- VERIFY state:
  - Correct sample: match++. When match reaches LOCK_CNT, go to LOCKED and clear match.
  - Wrong but legal sample: stay in VERIFY, match = 0; prev reloads from the new sample.
  - Illegal sample: go to HUNT.
  - No seq_err and no err_count change in VERIFY.
- LOCKED state:
  - Correct sample: stay in LOCKED. If the sample equals the start word (MSB hot, 1000 for WIDTH=4), rot_count++ with wraparound.
  - Wrong sample:
    - seq_err = 1 for one cycle; err_count++ (saturating).
    - Go to VERIFY with match = 0 if the sample is legal, otherwise go to HUNT.
- locked = 1 exactly when state is LOCKED. It drops in the same output cycle that seq_err is asserted.
- Counter boundaries:
  - rot_count 0xFF + 1 gives 0x00.
  - err_count at 0xFF stays at 0xFF, and seq_err still pulses.
- Reset asserted mid-run: immediate return to the reset values. Lock must be reacquired from HUNT after release.
- No combinational path from any input to any output.

Decomposition:
- Package ring_pkg:
  - State enum: HUNT, VERIFY, LOCKED.
  - Rotation direction constant: right.
  - Functions is_onehot(word) and onehot_to_index(word).
- Sub-module onehot_decoder: purely combinational, WIDTH input, producing legal and index. It is instantiated once.
- The top level holds the FSM, prev, match and both counters.

Test Plan:
- Reset, then a clean ring sampled every cycle, 1000,0100,0010,0001,1000,...:
  - locked rises after the 3rd sample (LOCK_CNT=2 transitions).
  - index tracks 3,2,1,0.
  - rot_count increments on each locked 1000; after 8 full rotations, rot_count = 8.
- Locked, then 0110 injected: seq_err pulses for exactly one cycle, err_count = 1, locked = 0, index_valid = 0, index holds. Clean sequence resumes; relock after 3 legal samples.
- Locked, then 0001 repeated twice: seq_err pulses on the repeat, FSM goes to VERIFY, and locked returns 2 correct transitions later.
- ring_valid toggled 1,0,0,1 on a clean ring: state, counters and index are frozen while ring_valid = 0, and no error occurs.
- Force 300 injected errors in LOCKED: err_count saturates at 255, and seq_err still pulses on each error. Run 256 rotations: rot_count wraps to 0.
- Assert reset asynchronously between clock edges while locked: all outputs are 0 immediately, before the next edge. After release, locked stays 0 until a legal sample plus 2 correct transitions.
